controller_sequencer: RTL
=========================

Name: controller_sequencer

Overview:
- Micro-operation sequencer that sits directly upstream of the controller ROM.
- Owns the registered 3-bit uOP counter and the ZERO/COUT flag register that the ROM decodes.
- Consumes the ROM's RESET_uOP and READ_FLAGS strobes.
- Adds run/single-step control, an idle park state (uOP = 3'b111, the ROM's reset microstate) and a runaway-instruction fault.

Parameters:
MAX_UOP, 6, highest legal uOP value; reaching it without RESET_uOP is a fault (range 1..6).
CNT_W, 16, width of the retired-instruction counter (optional feature only).

Ports:
CLK  in  1  system clock, all state updates on rising edge
RST_N  in  1  asynchronous active-low reset
RUN  in  1  level; 1 = free-run instructions back to back
STEP  in  1  rising edge requests exactly one instruction while RUN=0
CLR_FAULT  in  1  one-cycle pulse; clears FAULT and returns to PARK
RESET_uOP  in  1  from controller ROM; current uOP is the last of the instruction
READ_FLAGS  in  1  from controller ROM; latch ALU flags this edge
ALU_ZERO  in  1  ALU zero result
ALU_COUT  in  1  ALU carry out
uOP  out  3  current micro-operation to ROM (registered)
ZERO_FLAG  out  1  latched zero flag to ROM
COUT_FLAG  out  1  latched carry flag to ROM
BUSY  out  1  1 while in EXEC
INSTR_DONE  out  1  one-cycle pulse, cycle after the retiring uOP
FAULT  out  1  sticky runaway fault
INSTR_COUNT  out  CNT_W  retired instruction count (optional feature)

Behaviour:
- Reset (RST_N low, asynchronous): state = PARK, uOP = 3'b111, ZERO_FLAG = COUT_FLAG = 0, BUSY = 0, INSTR_DONE = 0, FAULT = 0, INSTR_COUNT = 0, step edge detector cleared. Reset asserted mid-instruction abandons it immediately.
- STEP is edge-detected internally: a request is STEP=1 now and 0 on the previous cycle. A request arriving outside PARK is dropped, not queued.
- PARK: uOP held at 7.
  - RUN=1 or a step request -> EXEC, uOP <= 0.
  - RUN and a step request together -> behaves as RUN.
- EXEC: BUSY = 1.
  - RESET_uOP=1 -> INSTR_DONE=1 next cycle.
    - If RUN=1: uOP <= 0, stay in EXEC.
    - Else: uOP <= 7, go to PARK.
  - Else if uOP == MAX_UOP -> uOP <= 7, FAULT <= 1, go to FAULT.
  - Else uOP <= uOP + 1.
  - RUN dropping mid-instruction finishes the current instruction, then parks.
- FAULT: uOP = 7, BUSY = 0, FAULT = 1. RUN and STEP are ignored. CLR_FAULT -> PARK, FAULT <= 0. CLR_FAULT in any other state has no effect.
- Flags: READ_FLAGS=1 at an edge (any state) -> ZERO_FLAG <= ALU_ZERO, COUT_FLAG <= ALU_COUT. Otherwise flags hold. Entering FAULT or PARK does not clear flags.
- uOP 0 (fetch) is never emitted from PARK/FAULT except via the EXEC entry transition; uOP 7 is never emitted while BUSY = 1.
- Latency: first fetch uOP appears one cycle after the RUN/step-request sample; an n-uOP instruction occupies n cycles in EXEC.

Optional Feature:
SEQ_INSTR_COUNT_EN
- Defined: INSTR_COUNT increments by 1 on every cycle INSTR_DONE is asserted, wraps from 2^CNT_W-1 to 0, and is cleared only by RST_N.
- Undefined: INSTR_COUNT tied to 0 and no counter flops are built.

Test Plan:
1. Hold RST_N low, then release with RUN=0 -> uOP=7, ZERO_FLAG=0, COUT_FLAG=0, BUSY=0, FAULT=0; state stays PARK for 10 cycles.
2. RUN=1, bench pulses RESET_uOP whenever uOP==3 -> uOP sequence 7,0,1,2,3,0,1,2,3; INSTR_DONE high on the cycle after each uOP=3; INSTR_COUNT=2 after two retirements with SEQ_INSTR_COUNT_EN defined.
3. RUN=0, STEP high for 3 cycles, RESET_uOP at uOP==5 -> one instruction only: 0..5 then 7, BUSY low. A second STEP edge at uOP==2 is ignored: exactly one INSTR_DONE.
4. READ_FLAGS=1 with ALU_ZERO=1, ALU_COUT=0 -> ZERO_FLAG=1, COUT_FLAG=0 next edge. Toggling the ALU inputs with READ_FLAGS=0 leaves flags unchanged.
5. RUN=1, never assert RESET_uOP, MAX_UOP=6 -> uOP 0..6, then 7 with FAULT=1, BUSY=0. RUN held high keeps FAULT. CLR_FAULT pulse -> PARK, FAULT=0, next cycle uOP=0.
6. RST_N pulled low asynchronously (between clock edges) while uOP=4 in EXEC -> uOP=7, BUSY=0, flags 0 immediately, without waiting for CLK.

Source files
------------

// File: rtl/controller_sequencer.sv
// controller_sequencer
//
// Micro-operation sequencer placed directly upstream of the controller ROM.
// Owns the registered 3-bit uOP counter and the ZERO/COUT flag register that
// the ROM decodes, and adds run/single-step control, an idle park state
// (uOP = 3'b111, the ROM's reset microstate) and a sticky runaway fault.
//
// Optional feature: define SEQ_INSTR_COUNT_EN to build the retired-instruction
// counter driving INSTR_COUNT; without it INSTR_COUNT is tied to zero.
//
// Ports:
//   CLK          system clock, rising edge
//   RST_N        asynchronous active-low reset
//   RUN          level, free-run instructions back to back
//   STEP         rising edge requests one instruction while parked
//   CLR_FAULT    pulse, clears FAULT and returns to PARK
//   RESET_uOP    from ROM, current uOP is the last of the instruction
//   READ_FLAGS   from ROM, latch ALU flags at this edge
//   ALU_ZERO     ALU zero result
//   ALU_COUT     ALU carry out
//   uOP          current micro-operation (registered)
//   ZERO_FLAG    latched zero flag
//   COUT_FLAG    latched carry flag
//   BUSY         high while executing
//   INSTR_DONE   one-cycle pulse, cycle after the retiring uOP
//   FAULT        sticky runaway fault
//   INSTR_COUNT  retired instruction count (optional feature)
module controller_sequencer #(
    parameter int unsigned MAX_UOP = 6,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             RUN,
    input  logic             STEP,
    input  logic             CLR_FAULT,
    input  logic             RESET_uOP,
    input  logic             READ_FLAGS,
    input  logic             ALU_ZERO,
    input  logic             ALU_COUT,
    output logic [2:0]       uOP,
    output logic             ZERO_FLAG,
    output logic             COUT_FLAG,
    output logic             BUSY,
    output logic             INSTR_DONE,
    output logic             FAULT,
    output logic [CNT_W-1:0] INSTR_COUNT
);

    typedef enum logic [1:0] {
        S_PARK  = 2'd0,
        S_EXEC  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam logic [2:0] LP_PARK_UOP = 3'b111;
    localparam logic [2:0] LP_MAX_UOP  = 3'(MAX_UOP);

    state_t     r_state;
    logic [2:0] r_uop;
    logic       r_zero;
    logic       r_cout;
    logic       r_busy;
    logic       r_done;
    logic       r_fault;
    logic       r_step_d;
    logic       w_step_req;

    // A step request is a 0->1 transition of STEP; only PARK consumes it.
    assign w_step_req = STEP & ~r_step_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= S_PARK;
            r_uop    <= LP_PARK_UOP;
            r_zero   <= 1'b0;
            r_cout   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_fault  <= 1'b0;
            r_step_d <= 1'b0;
        end else begin
            r_step_d <= STEP;
            r_done   <= 1'b0;

            // Flags are independent of sequencing state.
            if (READ_FLAGS) begin
                r_zero <= ALU_ZERO;
                r_cout <= ALU_COUT;
            end

            case (r_state)
                S_PARK: begin
                    if (RUN || w_step_req) begin
                        r_state <= S_EXEC;
                        r_uop   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (RESET_uOP) begin
                        r_done <= 1'b1;
                        if (RUN) begin
                            r_uop <= '0;
                        end else begin
                            r_state <= S_PARK;
                            r_uop   <= LP_PARK_UOP;
                            r_busy  <= 1'b0;
                        end
                    end else if (r_uop == LP_MAX_UOP) begin
                        r_state <= S_FAULT;
                        r_uop   <= LP_PARK_UOP;
                        r_busy  <= 1'b0;
                        r_fault <= 1'b1;
                    end else begin
                        r_uop <= r_uop + 3'd1;
                    end
                end
                S_FAULT: begin
                    if (CLR_FAULT) begin
                        r_state <= S_PARK;
                        r_fault <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_PARK;
                    r_uop   <= LP_PARK_UOP;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign uOP        = r_uop;
    assign ZERO_FLAG  = r_zero;
    assign COUT_FLAG  = r_cout;
    assign BUSY       = r_busy;
    assign INSTR_DONE = r_done;
    assign FAULT      = r_fault;

`ifdef SEQ_INSTR_COUNT_EN
    logic [CNT_W-1:0] r_instr_count;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_instr_count <= '0;
        end else if (r_done) begin
            r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end

    assign INSTR_COUNT = r_instr_count;
`else
    assign INSTR_COUNT = '0;
`endif

endmodule
